// File: rtl/wb_stage_pkg.sv
// Shared pipeline definitions: opcode constants, write-back FSM encoding
// and opcode classification helper.
package wb_stage_pkg;

    localparam logic [5:0] OP_NOP = 6'b110111;
    localparam logic [5:0] OP_LW  = 6'b010000;
    localparam logic [5:0] OP_SW  = 6'b011000;
    localparam logic [5:0] OP_JAL = 6'b101001;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MEM  = 1'b1
    } wb_state_e;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/wb_stage_if.sv
// Data-memory request/acknowledge bus between the write-back stage and memory.
interface wb_stage_if;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    modport master (output dm_req, dm_we, dm_addr, dm_wdata,
                    input  dm_ack, dm_rdata);
    modport slave  (input  dm_req, dm_we, dm_addr, dm_wdata,
                    output dm_ack, dm_rdata);
endinterface

// File: rtl/wb_stage_regfile.sv
// 32x32 register file: one write port, two combinational read ports with
// write-through bypass; register 0 is hardwired to zero.
module regfile (
    input  logic        clk,
    input  logic        rstd,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic        wr_en;

    assign wr_en = we && (waddr != 5'd0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) regs_d[waddr] = wdata;
    end

    always_ff @(posedge clk or posedge rstd) begin
        if (rstd) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    function automatic logic [31:0] rd_port(input logic [4:0] ra);
        if (ra == 5'd0)               return '0;
        else if (wr_en && ra == waddr) return wdata;
        else                          return regs_q[ra];
    endfunction

    assign rd1 = rd_port(ra1);
    assign rd2 = rd_port(ra2);
endmodule

// File: rtl/wb_stage.sv
// Write-back stage: retires ALU/JAL results, runs loads/stores through a
// two-state memory FSM that stalls the pipeline, and counts retirements.
module wb_stage
    import wb_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rstd,
    input  logic [31:0] pc_in,
    input  logic [5:0]  op_in,
    input  logic [31:0] ot_in,
    input  logic [4:0]  wreg_in,
    input  logic [31:0] alu_result_in,
    wb_stage_if.master  dm,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    output logic        stall,
    output logic [31:0] retire_cnt
);
    wb_state_e   state_q, state_d;
    logic        dm_we_q, dm_we_d;
    logic [31:0] dm_addr_q, dm_addr_d;
    logic [31:0] dm_wdata_q, dm_wdata_d;
    logic [4:0]  wreg_q, wreg_d;
    logic [31:0] retire_cnt_q, retire_cnt_d;

    logic        req, we_out, retire, rf_we;
    logic [31:0] addr_out, wdata_out, rf_wdata;
    logic [4:0]  rf_waddr;

    always_comb begin
        state_d    = state_q;
        dm_we_d    = dm_we_q;
        dm_addr_d  = dm_addr_q;
        dm_wdata_d = dm_wdata_q;
        wreg_d     = wreg_q;
        stall      = 1'b0;
        req        = 1'b0;
        we_out     = 1'b0;
        addr_out   = '0;
        wdata_out  = '0;
        retire     = 1'b0;
        rf_we      = 1'b0;
        rf_waddr   = wreg_in;
        rf_wdata   = alu_result_in;
        case (state_q)
            ST_IDLE: begin
                if (is_mem_op(op_in)) begin
                    stall      = 1'b1;
                    req        = 1'b1;
                    we_out     = (op_in == OP_SW);
                    addr_out   = alu_result_in;
                    wdata_out  = ot_in;
                    dm_we_d    = (op_in == OP_SW);
                    dm_addr_d  = alu_result_in;
                    dm_wdata_d = ot_in;
                    wreg_d     = wreg_in;
                    state_d    = ST_MEM;
                end else if (op_in != OP_NOP) begin
                    retire   = 1'b1;
                    rf_we    = 1'b1;
                    rf_wdata = (op_in == OP_JAL) ? pc_in + 32'd4 : alu_result_in;
                end
            end
            ST_MEM: begin
                // Bus is replayed from the copy captured at issue
                req       = 1'b1;
                we_out    = dm_we_q;
                addr_out  = dm_addr_q;
                wdata_out = dm_wdata_q;
                stall     = !dm.dm_ack;
                if (dm.dm_ack) begin
                    state_d  = ST_IDLE;
                    retire   = 1'b1;
                    rf_we    = !dm_we_q;
                    rf_waddr = wreg_q;
                    rf_wdata = dm.dm_rdata;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Reset silences the bus and stall at once, not at the next edge
        if (rstd) begin
            stall     = 1'b0;
            req       = 1'b0;
            we_out    = 1'b0;
            addr_out  = '0;
            wdata_out = '0;
            rf_we     = 1'b0;
            retire    = 1'b0;
        end
        retire_cnt_d = retire_cnt_q + {31'd0, retire};
    end

    always_ff @(posedge clk or posedge rstd) begin
        if (rstd) begin
            state_q      <= ST_IDLE;
            dm_we_q      <= 1'b0;
            dm_addr_q    <= '0;
            dm_wdata_q   <= '0;
            wreg_q       <= '0;
            retire_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            dm_we_q      <= dm_we_d;
            dm_addr_q    <= dm_addr_d;
            dm_wdata_q   <= dm_wdata_d;
            wreg_q       <= wreg_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign dm.dm_req   = req;
    assign dm.dm_we    = we_out;
    assign dm.dm_addr  = addr_out;
    assign dm.dm_wdata = wdata_out;
    assign retire_cnt  = retire_cnt_q;

    regfile u_regfile (
        .clk   (clk),
        .rstd  (rstd),
        .we    (rf_we),
        .waddr (rf_waddr),
        .wdata (rf_wdata),
        .ra1   (ra1),
        .ra2   (ra2),
        .rd1   (rd1),
        .rd2   (rd2)
    );
endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus a randomized
// instruction stream compared against an architectural register/count model.
module tb_wb_stage;
    import wb_stage_pkg::*;

    localparam logic [5:0] OP_ADD = 6'b000001;

    logic        clk = 1'b0;
    logic        rstd;
    logic [31:0] pc_in, ot_in, alu_result_in;
    logic [5:0]  op_in;
    logic [4:0]  wreg_in, ra1, ra2;
    logic [31:0] rd1, rd2, retire_cnt;
    logic        stall;

    wb_stage_if dm_if ();

    wb_stage dut (
        .clk           (clk),
        .rstd          (rstd),
        .pc_in         (pc_in),
        .op_in         (op_in),
        .ot_in         (ot_in),
        .wreg_in       (wreg_in),
        .alu_result_in (alu_result_in),
        .dm            (dm_if),
        .ra1           (ra1),
        .ra2           (ra2),
        .rd1           (rd1),
        .rd2           (rd2),
        .stall         (stall),
        .retire_cnt    (retire_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_cnt = '0;
    endfunction

    // Architectural read value: the value a register holds once this cycle's write lands
    function automatic logic [31:0] exp_rd(input logic [4:0] ra, input bit wen,
                                           input logic [4:0] wa, input logic [31:0] wd);
        if (ra == 5'd0) return '0;
        if (wen && wa == ra) return wd;
        return m_regs[ra];
    endfunction

    // Runs one instruction to completion, checking every cycle it occupies.
    task automatic exec(input string tag, input logic [5:0] op, input logic [31:0] pc,
                        input logic [31:0] ot, input logic [4:0] wreg, input logic [31:0] alu,
                        input int wait_n, input logic [31:0] rdata,
                        input int r1sel, input int r2sel,
                        output int stall_cycles, output int occ);
        bit mem;
        bit is_sw;
        int n_cyc;
        mem   = (op == OP_LW) || (op == OP_SW);
        is_sw = (op == OP_SW);
        n_cyc = mem ? wait_n + 2 : 1;
        stall_cycles = 0;
        occ = n_cyc;
        for (int c = 0; c < n_cyc; c++) begin
            bit          last, wen, inc;
            logic [2:0]  e_ctl;
            logic [31:0] e_addr, e_wdata, wd, e1, e2;
            last = (c == n_cyc - 1);
            @(negedge clk);
            pc_in = pc; op_in = op; ot_in = ot; wreg_in = wreg; alu_result_in = alu;
            ra1 = (r1sel < 0) ? 5'($urandom) : 5'(r1sel);
            ra2 = (r2sel < 0) ? 5'($urandom) : 5'(r2sel);
            dm_if.dm_ack   = (c == 0) ? 1'($urandom) : last;
            dm_if.dm_rdata = (mem && last) ? rdata : $urandom;
            if (!mem) begin
                e_ctl = 3'b000; e_addr = '0; e_wdata = '0;
                wen = (op != OP_NOP);
                wd  = (op == OP_JAL) ? pc + 32'd4 : alu;
                inc = (op != OP_NOP);
            end else begin
                e_ctl = {!last, 1'b1, is_sw};
                e_addr = alu; e_wdata = ot;
                wen = !is_sw && last && c > 0;
                wd  = rdata;
                inc = last;
            end
            e1 = exp_rd(ra1, wen, wreg, wd);
            e2 = exp_rd(ra2, wen, wreg, wd);
            #1;
            checks++;
            if ({stall, dm_if.dm_req, dm_if.dm_we} !== e_ctl) begin
                failures++;
                $display("FAIL %s ctl cyc%0d: got stall/req/we=%b exp %b", tag, c,
                         {stall, dm_if.dm_req, dm_if.dm_we}, e_ctl);
            end
            checks++;
            if (dm_if.dm_addr !== e_addr || dm_if.dm_wdata !== e_wdata) begin
                failures++;
                $display("FAIL %s bus cyc%0d: got addr=%h wdata=%h exp addr=%h wdata=%h",
                         tag, c, dm_if.dm_addr, dm_if.dm_wdata, e_addr, e_wdata);
            end
            checks++;
            if (rd1 !== e1) begin
                failures++;
                $display("FAIL %s rd1 cyc%0d ra1=%0d: got %h exp %h", tag, c, ra1, rd1, e1);
            end
            checks++;
            if (rd2 !== e2) begin
                failures++;
                $display("FAIL %s rd2 cyc%0d ra2=%0d: got %h exp %h", tag, c, ra2, rd2, e2);
            end
            checks++;
            if (retire_cnt !== m_cnt) begin
                failures++;
                $display("FAIL %s retire_cnt cyc%0d: got %0d exp %0d", tag, c, retire_cnt, m_cnt);
            end
            if (stall) stall_cycles++;
            @(posedge clk);
            if (wen && wreg != 5'd0) m_regs[wreg] = wd;
            if (inc) m_cnt = m_cnt + 32'd1;
        end
    endtask

    task automatic idle_read(input logic [4:0] a1, input logic [4:0] a2);
        @(negedge clk);
        op_in = OP_NOP; ra1 = a1; ra2 = a2; dm_if.dm_ack = 1'($urandom);
        #1;
    endtask

    task automatic test_reset();
        int sc, oc;
        rstd = 1'b1;
        op_in = OP_LW; pc_in = '0; ot_in = 32'h1111; wreg_in = 5'd1;
        alu_result_in = 32'h40; ra1 = 5'd1; ra2 = 5'd2;
        dm_if.dm_ack = 1'b0; dm_if.dm_rdata = '0;
        #1;
        checks++;
        if (stall !== 1'b0 || dm_if.dm_req !== 1'b0 || dm_if.dm_we !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctl: got stall=%b req=%b we=%b exp 0 0 0", stall, dm_if.dm_req, dm_if.dm_we);
        end
        repeat (2) @(posedge clk);
        checks++;
        if (retire_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_cnt: got %0d exp 0", retire_cnt);
        end
        @(negedge clk);
        op_in = OP_NOP;
        rstd = 1'b0;
        model_reset();
        for (int i = 0; i < 16; i++) exec("reset_regs", OP_NOP, 0, 0, 0, 0, 0, 0, i, i + 16, sc, oc);
    endtask

    task automatic test_alu();
        int sc, oc;
        exec("alu", OP_ADD, 32'h10, 0, 5'd5, 32'h1234, 0, 0, -1, -1, sc, oc);
        idle_read(5'd5, 5'd0);
        checks++;
        if (rd1 !== 32'h1234 || retire_cnt !== 32'd1 || sc != 0) begin
            failures++;
            $display("FAIL alu_readback: got rd1=%h cnt=%0d stalls=%0d exp 1234 1 0", rd1, retire_cnt, sc);
        end
    endtask

    task automatic test_lw();
        int sc, oc;
        exec("lw", OP_LW, 32'h14, 32'h5, 5'd8, 32'h40, 3, 32'hDEADBEEF, -1, -1, sc, oc);
        idle_read(5'd8, 5'd5);
        checks++;
        if (sc != 4 || rd1 !== 32'hDEADBEEF || rd2 !== 32'h1234 || retire_cnt !== 32'd2) begin
            failures++;
            $display("FAIL lw_result: got stalls=%0d r8=%h r5=%h cnt=%0d exp 4 deadbeef 1234 2",
                     sc, rd1, rd2, retire_cnt);
        end
    endtask

    task automatic test_sw();
        int sc, oc;
        exec("sw", OP_SW, 32'h18, 32'hCAFE, 5'd8, 32'h80, 0, 32'h99, -1, -1, sc, oc);
        idle_read(5'd8, 5'd5);
        checks++;
        if (oc != 2 || sc != 1 || rd1 !== 32'hDEADBEEF || retire_cnt !== 32'd3) begin
            failures++;
            $display("FAIL sw_result: got occ=%0d stalls=%0d r8=%h cnt=%0d exp 2 1 deadbeef 3",
                     oc, sc, rd1, retire_cnt);
        end
    endtask

    task automatic test_reg0_bypass();
        int sc, oc;
        exec("reg0", OP_ADD, 0, 0, 5'd0, 32'hFFFF, 0, 0, 0, 0, sc, oc);
        @(negedge clk);
        op_in = OP_ADD; wreg_in = 5'd3; alu_result_in = 32'h77; ra1 = 5'd0; ra2 = 5'd3;
        #1;
        checks++;
        if (rd1 !== 32'd0 || rd2 !== 32'h77) begin
            failures++;
            $display("FAIL bypass: got rd1=%h rd2=%h exp 0 77", rd1, rd2);
        end
        @(posedge clk);
        m_regs[3] = 32'h77;
        m_cnt = m_cnt + 32'd1;
    endtask

    task automatic test_jal();
        int sc, oc;
        exec("jal", OP_JAL, 32'h100, 0, 5'd31, 32'h5555, 0, 0, -1, -1, sc, oc);
        exec("jal_wrap", OP_JAL, 32'hFFFFFFFE, 0, 5'd30, 0, 0, 0, -1, -1, sc, oc);
        idle_read(5'd31, 5'd30);
        checks++;
        if (rd1 !== 32'h104 || rd2 !== 32'h2) begin
            failures++;
            $display("FAIL jal_link: got r31=%h r30=%h exp 104 2", rd1, rd2);
        end
    endtask

    task automatic test_random();
        int sc, oc;
        logic [5:0] op;
        for (int n = 0; n < 250; n++) begin
            case ($urandom_range(0, 5))
                0: op = OP_NOP;
                1: op = OP_LW;
                2: op = OP_SW;
                3: op = OP_JAL;
                default: begin
                    op = 6'($urandom);
                    while (op == OP_NOP || op == OP_LW || op == OP_SW || op == OP_JAL)
                        op = 6'($urandom);
                end
            endcase
            exec("rand", op, $urandom, $urandom, 5'($urandom), $urandom,
                 int'($urandom_range(0, 3)), $urandom, -1, -1, sc, oc);
        end
    endtask

    task automatic test_reset_mid_lw();
        int sc, oc;
        @(negedge clk);
        op_in = OP_LW; alu_result_in = 32'h55; wreg_in = 5'd9; dm_if.dm_ack = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (dm_if.dm_req !== 1'b1 || stall !== 1'b1) begin
            failures++;
            $display("FAIL midlw_inflight: got req=%b stall=%b exp 1 1", dm_if.dm_req, stall);
        end
        rstd = 1'b1;
        ra1 = 5'd3;
        #1;
        checks++;
        if (dm_if.dm_req !== 1'b0 || stall !== 1'b0 || retire_cnt !== 32'd0 || rd1 !== 32'd0) begin
            failures++;
            $display("FAIL midlw_reset: got req=%b stall=%b cnt=%0d r3=%h exp 0 0 0 0",
                     dm_if.dm_req, stall, retire_cnt, rd1);
        end
        @(negedge clk);
        rstd = 1'b0;
        op_in = OP_NOP; dm_if.dm_ack = 1'b1; dm_if.dm_rdata = 32'hBAD0BAD0; ra1 = 5'd9;
        #1;
        checks++;
        if (stall !== 1'b0 || dm_if.dm_req !== 1'b0 || rd1 !== 32'd0) begin
            failures++;
            $display("FAIL late_ack: got stall=%b req=%b r9=%h exp 0 0 0", stall, dm_if.dm_req, rd1);
        end
        model_reset();
        for (int i = 0; i < 16; i++) exec("post_reset", OP_NOP, 0, 0, 0, 0, 0, 0, i, i + 16, sc, oc);
    endtask

    task automatic test_retire_wrap();
        @(negedge clk);
        op_in = OP_ADD; wreg_in = 5'd4; alu_result_in = 32'h1;
        force dut.retire_cnt_q = 32'hFFFFFFFF;
        #1;
        release dut.retire_cnt_q;
        #1;
        checks++;
        if (retire_cnt !== 32'hFFFFFFFF) begin
            failures++;
            $display("FAIL wrap_preload: got %h exp ffffffff", retire_cnt);
        end
        @(posedge clk);
        m_regs[4] = 32'h1;
        m_cnt = '0;
        idle_read(5'd4, 5'd0);
        checks++;
        if (retire_cnt !== 32'd0 || rd1 !== 32'h1) begin
            failures++;
            $display("FAIL wrap: got cnt=%h r4=%h exp 0 1", retire_cnt, rd1);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_lw();
        test_sw();
        test_reg0_bypass();
        test_jal();
        test_random();
        test_reset_mid_lw();
        test_random();
        test_retire_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
